scope_capture_ctrl: RTL
=======================

SCOPE_CAPTURE_CTRL -- requirements
Module: scope_capture_ctrl

Interface
REQ-001 Parameter: DEPTH, default 1280, capture buffer depth in samples (5*256).
REQ-002 Parameter: AW, default 11, buffer address width.
REQ-003 Parameter: SW, default 19, signed sample width.
REQ-004 Parameter: PRE, default 256, pre-trigger samples retained; legal range 1..DEPTH-2.
REQ-005 Parameter: AUTO_TMO, default 65536, auto-trigger timeout in valid samples (used only with SCOPE_AUTO_TRIG_EN).
REQ-006 The block uses one clock; reset is synchronous and active-high.
REQ-007 Port: CLOCK_50  in  1  system clock; all logic on rising edge.
REQ-008 Port: reset  in  1  synchronous active-high reset.
REQ-009 Port: sample_valid  in  1  qualifies sample this cycle.
REQ-010 Port: sample  in  SW  signed input sample.
REQ-011 Port: trig_level  in  SW  signed trigger threshold.
REQ-012 Port: trig_rise  in  1  1 = rising-edge trigger, 0 = falling-edge.
REQ-013 Port: arm  in  1  single-cycle pulse starting an acquisition.
REQ-014 Port: single  in  1  1 = single-shot, 0 = continuous re-arm.
REQ-015 Port: vsync_n  in  1  display vertical sync, active low.
REQ-016 Port: wr_en / wr_addr / wr_data  out  1 / AW / SW  buffer write port.
REQ-017 Port: rd_base  out  AW  buffer address of oldest displayed sample.
REQ-018 Port: frame_ready  out  1  completed capture held for display.
REQ-019 Port: auto_trig  out  1  last capture was forced by timeout.
REQ-020 Port: state  out  3  current FSM state encoding.

Function
REQ-021 FSM states SHALL be IDLE=0, FILL=1, ARMED=2, POST=3, DONE=4.
REQ-022 IDLE: arm -> FILL, clearing write pointer, pre-count and post-count; else hold.
REQ-023 FILL/ARMED/POST: each sample_valid cycle SHALL write sample at wr_ptr; wr_en/wr_addr/wr_data registered, asserted exactly one cycle after sample_valid (latency 1); no valid, no write, counters stall.
REQ-024 wr_ptr SHALL increment per write and wrap DEPTH-1 -> 0.
REQ-025 FILL -> ARMED when the PRE-th sample is written.
REQ-026 Trigger condition (ARMED only): rising: prev < trig_level and sample >= trig_level; falling: prev > trig_level and sample <= trig_level; signed compare; prev = last valid sample since entering FILL.
REQ-027 On trigger: sample written normally, trig address latched, rd_base = (trig address - PRE) mod DEPTH, -> POST.
REQ-028 POST -> DONE when DEPTH-PRE-1 further samples written; DONE writes nothing.
REQ-029 frame_ready SHALL be 1 only in DONE.
REQ-030 DONE: on falling edge of vsync_n (detected against its previous-cycle value) with single=0 -> FILL; with single=1 hold until arm -> FILL.
REQ-031 arm in FILL, ARMED or POST SHALL be ignored; arm coincident with vsync_n falling edge in DONE -> FILL once.
REQ-032 rd_base SHALL change only on trigger and hold through DONE.
REQ-033 A trigger on the sample that completes FILL is not detected (evaluation starts in ARMED).

Reset
REQ-034 reset SHALL override all inputs, including mid-acquisition: state IDLE, wr_en 0, wr_addr 0, wr_data 0, rd_base 0, frame_ready 0, auto_trig 0, counters and prev cleared, vsync_n history set to 1.

Configuration
REQ-035 Macro SCOPE_AUTO_TRIG_EN defined: ARMED with AUTO_TMO consecutive valid samples and no trigger SHALL force a trigger on the next valid sample, setting auto_trig 1 until the next FILL entry (natural trigger clears it to 0).
REQ-036 Macro undefined: ARMED waits indefinitely; auto_trig tied 0; no timeout counter.

Verification
REQ-037 Reset, arm, ramp -4096..+4095 step 16, trig_level 0, trig_rise 1 -> trigger at sample 0x0, rd_base = trig addr-256 mod 1280, DONE after 1023 post writes.
REQ-038 Falling trigger, sine amplitude 3000, single=1 -> one capture, frame_ready stays 1 across 3 vsync_n edges, re-arm only on arm.
REQ-039 Continuous mode, vsync_n falling in DONE -> FILL next cycle, wr_addr continues from wrap position, frame_ready drops.
REQ-040 reset asserted mid-POST -> next cycle IDLE, all outputs 0, no writes until arm.
REQ-041 sample_valid toggled 1-of-3 cycles -> write count per capture exactly 1280, wr_en 1 cycle after each valid.
REQ-042 SCOPE_AUTO_TRIG_EN with AUTO_TMO=64, constant input 100 -> forced trigger after 64 valid samples, auto_trig 1; undefined -> remains ARMED.

Source files
------------

// File: rtl/scope_capture_ctrl_if.sv
// scope_capture_ctrl_if -- bundle of the sample, trigger, control, buffer-write
// and status signals of the oscilloscope capture controller.
// The master side drives samples and controls; the slave side is the
// controller itself and drives the buffer write port and the status outputs.

interface scope_capture_ctrl_if #(
   parameter int AW = 11,
   parameter int SW = 19
);

   logic                 sample_valid;
   logic signed [SW-1:0] sample;
   logic signed [SW-1:0] trig_level;
   logic                 trig_rise;
   logic                 arm;
   logic                 single;
   logic                 vsync_n;

   logic                 wr_en;
   logic        [AW-1:0] wr_addr;
   logic signed [SW-1:0] wr_data;
   logic        [AW-1:0] rd_base;
   logic                 frame_ready;
   logic                 auto_trig;
   logic          [2:0]  state;

   modport master (
      output sample_valid, sample, trig_level, trig_rise, arm, single, vsync_n,
      input  wr_en, wr_addr, wr_data, rd_base, frame_ready, auto_trig, state
   );

   modport slave (
      input  sample_valid, sample, trig_level, trig_rise, arm, single, vsync_n,
      output wr_en, wr_addr, wr_data, rd_base, frame_ready, auto_trig, state
   );

endinterface

// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl -- oscilloscope capture controller.
// Streams samples into a circular DEPTH-entry buffer, keeps PRE samples of
// history ahead of an edge trigger, fills the rest of the buffer after the
// trigger and then holds the frame for the display until the next vertical
// sync (continuous mode) or the next arm pulse (single-shot mode).
// Optional feature: define SCOPE_AUTO_TRIG_EN to force a trigger after
// AUTO_TMO valid samples spent waiting in ARMED; auto_trig flags such frames.

module scope_capture_ctrl #(
   parameter int DEPTH    = 1280,
   parameter int AW       = 11,
   parameter int SW       = 19,
   parameter int PRE      = 256,
   parameter int AUTO_TMO = 65536
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   scope_capture_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      ARMED = 3'd2,
      POST  = 3'd3,
      DONE  = 3'd4
   } CaptureState;

   localparam logic [AW-1:0] DEPTH_LAST      = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PRE_ADDR        = AW'(PRE);
   localparam logic [AW-1:0] PRE_LAST        = AW'(PRE - 1);
   localparam logic [AW-1:0] POST_LAST       = AW'(DEPTH - PRE - 2);
   localparam logic [AW-1:0] DEPTH_MINUS_PRE = AW'(DEPTH - PRE);

   CaptureState          state_q, state_d;
   logic        [AW-1:0] wrPtr_q, wrPtr_d;
   logic        [AW-1:0] preCnt_q, preCnt_d;
   logic        [AW-1:0] postCnt_q, postCnt_d;
   logic signed [SW-1:0] prev_q, prev_d;
   logic        [AW-1:0] rdBase_q, rdBase_d;
   logic                 wrEn_q, wrEn_d;
   logic        [AW-1:0] wrAddr_q, wrAddr_d;
   logic signed [SW-1:0] wrData_q, wrData_d;
   logic                 vsyncPrev_q;

   logic                 vsyncFall;
   logic                 riseHit;
   logic                 fallHit;
   logic                 crossHit;
   logic                 autoFire;
   logic                 enterFill;
   logic                 fireTrig;
   logic        [AW-1:0] wrPtrNext;
   logic        [AW-1:0] trigBase;

   // Edge detection on the display sync and the signed level-crossing tests.
   // The previous sample is the last valid one seen since the capture began,
   // so idle cycles between valid samples never create a false crossing.
   always_comb begin
      vsyncFall = vsyncPrev_q & ~bus.vsync_n;
      riseHit   = (prev_q < bus.trig_level) && (bus.sample >= bus.trig_level);
      fallHit   = (prev_q > bus.trig_level) && (bus.sample <= bus.trig_level);
      crossHit  = bus.trig_rise ? riseHit : fallHit;
   end

   // Pointer arithmetic: the circular write pointer advance and the address
   // of the oldest retained pre-trigger sample if the current write triggers.
   always_comb begin
      wrPtrNext = (wrPtr_q == DEPTH_LAST) ? '0 : wrPtr_q + AW'(1);
      if (wrPtr_q >= PRE_ADDR) begin
         trigBase = wrPtr_q - PRE_ADDR;
      end else begin
         trigBase = wrPtr_q + DEPTH_MINUS_PRE;
      end
   end

   // Next-state logic for the capture FSM together with the buffer write
   // port. Every valid sample in FILL, ARMED or POST is written at the
   // current pointer; the write strobe is registered so it appears one
   // cycle after the qualifying sample. Counters only move on valid samples.
   always_comb begin
      state_d   = state_q;
      wrPtr_d   = wrPtr_q;
      preCnt_d  = preCnt_q;
      postCnt_d = postCnt_q;
      prev_d    = prev_q;
      rdBase_d  = rdBase_q;
      wrEn_d    = 1'b0;
      wrAddr_d  = wrAddr_q;
      wrData_d  = wrData_q;
      enterFill = 1'b0;
      fireTrig  = 1'b0;

      if (((state_q == FILL) || (state_q == ARMED) || (state_q == POST)) &&
          bus.sample_valid) begin
         wrEn_d   = 1'b1;
         wrAddr_d = wrPtr_q;
         wrData_d = bus.sample;
         wrPtr_d  = wrPtrNext;
         prev_d   = bus.sample;
      end

      case (state_q)
         IDLE: begin
            if (bus.arm) begin
               state_d   = FILL;
               wrPtr_d   = '0;
               preCnt_d  = '0;
               postCnt_d = '0;
               enterFill = 1'b1;
            end
         end
         FILL: begin
            if (bus.sample_valid) begin
               if (preCnt_q == PRE_LAST) begin
                  state_d = ARMED;
               end else begin
                  preCnt_d = preCnt_q + AW'(1);
               end
            end
         end
         ARMED: begin
            if (bus.sample_valid && (crossHit || autoFire)) begin
               fireTrig  = 1'b1;
               state_d   = POST;
               postCnt_d = '0;
               rdBase_d  = trigBase;
            end
         end
         POST: begin
            if (bus.sample_valid) begin
               if (postCnt_q == POST_LAST) begin
                  state_d = DONE;
               end else begin
                  postCnt_d = postCnt_q + AW'(1);
               end
            end
         end
         DONE: begin
            if ((vsyncFall && !bus.single) || (bus.single && bus.arm)) begin
               state_d   = FILL;
               preCnt_d  = '0;
               postCnt_d = '0;
               enterFill = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, pointer, history and write-port registers with synchronous reset.
   // The sync history resets high so a low vsync_n right after reset is not
   // mistaken for a falling edge.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q     <= IDLE;
         wrPtr_q     <= '0;
         preCnt_q    <= '0;
         postCnt_q   <= '0;
         prev_q      <= '0;
         rdBase_q    <= '0;
         wrEn_q      <= 1'b0;
         wrAddr_q    <= '0;
         wrData_q    <= '0;
         vsyncPrev_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         wrPtr_q     <= wrPtr_d;
         preCnt_q    <= preCnt_d;
         postCnt_q   <= postCnt_d;
         prev_q      <= prev_d;
         rdBase_q    <= rdBase_d;
         wrEn_q      <= wrEn_d;
         wrAddr_q    <= wrAddr_d;
         wrData_q    <= wrData_d;
         vsyncPrev_q <= bus.vsync_n;
      end
   end

`ifdef SCOPE_AUTO_TRIG_EN
   localparam int           TW        = $clog2(AUTO_TMO + 1);
   localparam logic [TW-1:0] TMO_LIMIT = TW'(AUTO_TMO);

   logic [TW-1:0] tmoCnt_q;
   logic          autoTrig_q;

   assign autoFire = (tmoCnt_q == TMO_LIMIT);

   // Timeout counter: counts valid samples that reach ARMED without a
   // trigger and saturates at the limit, which forces the next valid sample
   // to trigger. Outside ARMED it is held at zero.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         tmoCnt_q <= '0;
      end else if (state_q != ARMED) begin
         tmoCnt_q <= '0;
      end else if (bus.sample_valid && !fireTrig && (tmoCnt_q != TMO_LIMIT)) begin
         tmoCnt_q <= tmoCnt_q + TW'(1);
      end
   end

   // Auto-trigger flag: set when a frame was forced by the timeout, cleared
   // by a natural trigger and by every new acquisition start.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         autoTrig_q <= 1'b0;
      end else if (enterFill) begin
         autoTrig_q <= 1'b0;
      end else if (fireTrig) begin
         autoTrig_q <= ~crossHit;
      end
   end

   assign bus.auto_trig = autoTrig_q;
`else
   logic unusedAutoTrig;

   assign autoFire       = 1'b0;
   assign bus.auto_trig  = 1'b0;
   assign unusedAutoTrig = enterFill ^ fireTrig ^ (AUTO_TMO > 0);
`endif

   assign bus.wr_en       = wrEn_q;
   assign bus.wr_addr     = wrAddr_q;
   assign bus.wr_data     = wrData_q;
   assign bus.rd_base     = rdBase_q;
   assign bus.frame_ready = (state_q == DONE);
   assign bus.state       = state_q;

endmodule
